pll_scan_reader: RTL and testbench

PLL_SCAN_READER -- requirements
Module: pll_scan_reader

---
 rtl/pll_scan_reader_pkg.sv | 25 ++
 rtl/pll_scan_reader.sv | 141 ++++++++++++++
 tb/tb_pll_scan_reader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_scan_reader_pkg.sv
// Shared clocking definitions for the PLL reconfiguration writer and the
// scan-chain readback block: chain geometry, ROM width and FSM encoding.
package pll_scan_reader_pkg;

    localparam int CHAIN_LEN_DEF = 144;
    localparam int MAX_IDX_DEF   = 96;
    localparam int ROM_AW        = 14;
    localparam int RD_WORDS      = 9;
    localparam int RD_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETADR = 3'd1,
        ST_PRIME  = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_FIN    = 3'd5
    } scan_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        sat_inc = (inc && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/pll_scan_reader.sv
// Reads the PLL scan chain back by rotating it once through scandata, while
// comparing every bit against the clocking ROM image for the chosen index.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; invalid index goes straight to FIN
// SETADR | load rom_addr with the top address of the image
// PRIME  | ROM fetches the first bit, address steps down
// SHIFT  | CHAIN_LEN scan clocks: capture bit, compare against rom_q
// FLUSH  | fold in the last registered compare result, latch match
// FIN    | one-cycle done pulse
module pll_scan_reader
    import pll_scan_reader_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int MAX_IDX   = MAX_IDX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        freq_idx,
    input  logic              scandataout,
    output logic              scanclkena,
    output logic              scandata,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic              rom_q,
    input  logic [3:0]        rd_sel,
    output logic [15:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic              err_idx,
    output logic [7:0]        mismatch_cnt
);

    localparam int CNT_W = $clog2(CHAIN_LEN);
    localparam int CAP_W = (CHAIN_LEN > RD_WORDS*RD_W) ? CHAIN_LEN : RD_WORDS*RD_W;
    localparam int SEL_W = $clog2(CAP_W);

    scan_state_t            state, state_nxt;
    logic [7:0]             idx_q;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CHAIN_LEN-1:0]   cap;
    logic [CAP_W-1:0]       cap_ext;
    logic [SEL_W-1:0]       rd_base;
    logic                   diff_q;
    logic                   idx_ok;
    logic                   last_bit;
    logic [7:0]             cnt_nxt;
    logic [ROM_AW-1:0]      rom_base;

    assign idx_ok   = (freq_idx != 8'd0) && (freq_idx <= 8'(MAX_IDX));
    assign last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign rom_base = ROM_AW'(idx_q) * ROM_AW'(CHAIN_LEN) - ROM_AW'(1);
    assign cnt_nxt  = sat_inc(mismatch_cnt, diff_q);

    // The chain is recirculated so a full readback leaves the PLL untouched.
    assign scandata   = scandataout;
    assign scanclkena = (state == ST_SHIFT);
    assign busy       = (state == ST_SETADR) || (state == ST_PRIME) ||
                        (state == ST_SHIFT)  || (state == ST_FLUSH);
    assign done       = (state == ST_FIN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; start outside IDLE is simply not looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = idx_ok ? ST_SETADR : ST_FIN;
            ST_SETADR: state_nxt = ST_PRIME;
            ST_PRIME:  state_nxt = ST_SHIFT;
            ST_SHIFT:  if (last_bit) state_nxt = ST_FLUSH;
            ST_FLUSH:  state_nxt = ST_FIN;
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Address walk, capture, pipelined compare and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            rom_addr     <= '0;
            bit_cnt      <= '0;
            cap          <= '0;
            diff_q       <= 1'b0;
            mismatch_cnt <= '0;
            match        <= 1'b0;
            err_idx      <= 1'b0;
        end else begin
            // rom_q during SHIFT cycle k belongs to bit k; compare result lands a cycle later.
            diff_q <= (state == ST_SHIFT) && (scandataout != rom_q);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        match <= 1'b0;
                        if (idx_ok) begin
                            idx_q        <= freq_idx;
                            err_idx      <= 1'b0;
                            mismatch_cnt <= '0;
                            cap          <= '0;
                        end else begin
                            err_idx <= 1'b1;
                        end
                    end
                end
                ST_SETADR: rom_addr <= rom_base;
                ST_PRIME: begin
                    rom_addr <= rom_addr - 1'b1;
                    bit_cnt  <= '0;
                end
                ST_SHIFT: begin
                    rom_addr     <= rom_addr - 1'b1;
                    cap[bit_cnt] <= scandataout;
                    bit_cnt      <= bit_cnt + 1'b1;
                    mismatch_cnt <= cnt_nxt;
                end
                ST_FLUSH: begin
                    mismatch_cnt <= cnt_nxt;
                    match        <= (cnt_nxt == 8'd0);
                end
                default: ;
            endcase
        end
    end

    // Word readout of the capture register, zero beyond the last word.
    always_comb begin
        cap_ext                 = '0;
        cap_ext[CHAIN_LEN-1:0]  = cap;
        rd_base                 = SEL_W'({rd_sel, 4'h0});
        rd_data                 = '0;
        if (rd_sel < 4'(RD_WORDS)) rd_data = cap_ext[rd_base +: RD_W];
    end

endmodule

// File: tb/tb_pll_scan_reader.sv
// Bench for pll_scan_reader: behavioural scan chain and ROM, random images.
module tb_pll_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [7:0]  freq_idx = '0;
    logic        scandataout, scanclkena, scandata;
    logic [13:0] rom_addr;
    logic        rom_q = 1'b0;
    logic [3:0]  rd_sel = '0;
    logic [15:0] rd_data;
    logic        busy, done, match, err_idx;
    logic [7:0]  mismatch_cnt;

    logic        start2 = 1'b0;
    logic [7:0]  freq_idx2 = '0;
    logic        scandataout2, scanclkena2, scandata2;
    logic [13:0] rom_addr2;
    logic        rom_q2 = 1'b0;
    logic [3:0]  rd_sel2 = '0;
    logic [15:0] rd_data2;
    logic        busy2, done2, match2, err_idx2;
    logic [7:0]  mismatch_cnt2;

    bit          rom_mem [16384];
    logic [143:0] chain, chain_init;
    logic [299:0] chain2, chain2_init;
    logic        load = 1'b0, load2 = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    int lat, ena_cnt, done_cnt, busy_cnt, busy_after;
    logic m_o, e_o;
    logic [7:0] mc_o;

    always #20 clk = ~clk;

    pll_scan_reader u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .freq_idx(freq_idx),
        .scandataout(scandataout), .scanclkena(scanclkena), .scandata(scandata),
        .rom_addr(rom_addr), .rom_q(rom_q), .rd_sel(rd_sel), .rd_data(rd_data),
        .busy(busy), .done(done), .match(match), .err_idx(err_idx),
        .mismatch_cnt(mismatch_cnt)
    );

    pll_scan_reader #(.CHAIN_LEN(300), .MAX_IDX(40)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .freq_idx(freq_idx2),
        .scandataout(scandataout2), .scanclkena(scanclkena2), .scandata(scandata2),
        .rom_addr(rom_addr2), .rom_q(rom_q2), .rd_sel(rd_sel2), .rd_data(rd_data2),
        .busy(busy2), .done(done2), .match(match2), .err_idx(err_idx2),
        .mismatch_cnt(mismatch_cnt2)
    );

    // Synchronous ROM with one-cycle read latency.
    always @(posedge clk) begin
        rom_q  <= rom_mem[rom_addr];
        rom_q2 <= rom_mem[rom_addr2];
    end

    // PLL scan chains: bit 0 exits first, scandata enters at the top.
    assign scandataout  = chain[0];
    assign scandataout2 = chain2[0];
    always @(posedge clk) begin
        if (load)            chain <= chain_init;
        else if (scanclkena) chain <= {scandata, chain[143:1]};
        if (load2)            chain2 <= chain2_init;
        else if (scanclkena2) chain2 <= {scandata2, chain2[299:1]};
    end

    // Expected image: chain bit k must equal ROM[idx*len-1-k].
    function automatic logic [143:0] exp_img(input int idx);
        logic [143:0] v;
        for (int k = 0; k < 144; k++) v[k] = rom_mem[(idx*144 - 1 - k) % 16384];
        return v;
    endfunction

    function automatic logic [299:0] exp_img300(input int idx);
        logic [299:0] v;
        for (int k = 0; k < 300; k++) v[k] = rom_mem[(idx*300 - 1 - k) % 16384];
        return v;
    endfunction

    function automatic int ref_mismatch(input logic [143:0] a, input logic [143:0] b);
        int n = 0;
        for (int k = 0; k < 144; k++) if (a[k] != b[k]) n++;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic load_chain(input logic [143:0] img);
        @(negedge clk); chain_init = img; load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    // Issue one request and record what the block did until a few cycles after done.
    task automatic do_read(input int idx, input int restart_at);
        lat = 0; ena_cnt = 0; done_cnt = 0; busy_cnt = 0; busy_after = 0;
        m_o = 1'b0; e_o = 1'b0; mc_o = '0;
        @(negedge clk); start = 1'b1; freq_idx = 8'(idx);
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (scanclkena) ena_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat == 0) begin lat = c; m_o = match; e_o = err_idx; mc_o = mismatch_cnt; end
            end
            if (lat != 0 && c == lat + 3) busy_after = int'(busy);
            if (restart_at > 0 && scanclkena && ena_cnt == restart_at) begin
                start = 1'b1; freq_idx = 8'd20;
            end else start = 1'b0;
            if (lat != 0 && c >= lat + 4) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests_run++;
        if ({scanclkena, busy, done, match, err_idx} !== 5'b0 || mismatch_cnt !== 8'd0 || rom_addr !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ena=%b busy=%b done=%b match=%b err=%b cnt=%0d addr=%0d, want all 0",
                     scanclkena, busy, done, match, err_idx, mismatch_cnt, rom_addr);
        end
        for (int j = 0; j < 16; j += 5) begin
            rd_sel = 4'(j); #1;
            tests_run++;
            if (rd_data !== 16'h0) begin
                tests_failed++; $display("FAIL reset_rd_data sel=%0d: got %h want 0000", j, rd_data);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_match;
        logic [143:0] img;
        img = exp_img(10);
        load_chain(img);
        do_read(10, 0);
        tests_run++; if (lat != 148) begin tests_failed++; $display("FAIL match_latency: got %0d want 148", lat); end
        tests_run++; if (ena_cnt != 144) begin tests_failed++; $display("FAIL match_ena_cycles: got %0d want 144", ena_cnt); end
        tests_run++; if (busy_cnt != 147) begin tests_failed++; $display("FAIL match_busy_cycles: got %0d want 147", busy_cnt); end
        tests_run++; if (m_o !== 1'b1 || mc_o !== 8'd0 || e_o !== 1'b0) begin
            tests_failed++; $display("FAIL match_result: match=%b cnt=%0d err=%b want 1 0 0", m_o, mc_o, e_o);
        end
        tests_run++; if (chain !== img) begin tests_failed++; $display("FAIL match_chain_intact: got %h want %h", chain, img); end
        for (int j = 0; j < 16; j++) begin
            rd_sel = 4'(j); #1;
            tests_run++;
            if (rd_data !== ((j < 9) ? img[16*j +: 16] : 16'h0)) begin
                tests_failed++;
                $display("FAIL match_rd_data sel=%0d: got %h want %h", j, rd_data, (j < 9) ? img[16*j +: 16] : 16'h0);
            end
        end
    endtask

    task automatic test_flip;
        logic [143:0] img, e;
        e = exp_img(10);
        img = e; img[0] = ~img[0]; img[143] = ~img[143];
        load_chain(img);
        do_read(10, 0);
        tests_run++; if (m_o !== 1'b0 || mc_o !== 8'd2) begin
            tests_failed++; $display("FAIL flip_result: match=%b cnt=%0d want 0 2", m_o, mc_o);
        end
        rd_sel = 4'd0; #1;
        tests_run++; if (rd_data[0] !== ~e[0]) begin tests_failed++; $display("FAIL flip_bit0: got %b want %b", rd_data[0], ~e[0]); end
        rd_sel = 4'd8; #1;
        tests_run++; if (rd_data[15] !== ~e[143]) begin tests_failed++; $display("FAIL flip_bit143: got %b want %b", rd_data[15], ~e[143]); end
    endtask

    task automatic test_invalid;
        int bad [2] = '{0, 97};
        for (int i = 0; i < 2; i++) begin
            do_read(bad[i], 0);
            tests_run++;
            if (lat != 1 || ena_cnt != 0 || busy_cnt != 0 || e_o !== 1'b1 || m_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL invalid_idx=%0d: lat=%0d ena=%0d busy=%0d err=%b match=%b want 1 0 0 1 0",
                         bad[i], lat, ena_cnt, busy_cnt, e_o, m_o);
            end
        end
    endtask

    task automatic test_inverted;
        logic [143:0] img;
        img = ~exp_img(10);
        load_chain(img);
        do_read(10, 0);
        tests_run++; if (m_o !== 1'b0 || mc_o !== 8'(ref_mismatch(img, exp_img(10)))) begin
            tests_failed++; $display("FAIL inverted_result: match=%b cnt=%0d want 0 %0d", m_o, mc_o, ref_mismatch(img, exp_img(10)));
        end
    endtask

    task automatic test_saturate;
        int l2 = 0;
        @(negedge clk); chain2_init = ~exp_img300(5); load2 = 1'b1;
        @(negedge clk); load2 = 1'b0; start2 = 1'b1; freq_idx2 = 8'd5;
        @(negedge clk); start2 = 1'b0;
        for (int c = 1; c <= 700; c++) begin
            if (done2) begin l2 = c; break; end
            @(negedge clk);
        end
        tests_run++;
        if (l2 != 304 || mismatch_cnt2 !== 8'd255 || match2 !== 1'b0) begin
            tests_failed++; $display("FAIL saturate: lat=%0d cnt=%0d match=%b want 304 255 0", l2, mismatch_cnt2, match2);
        end
        tests_run++;
        if (chain2 !== chain2_init) begin tests_failed++; $display("FAIL saturate_chain_intact: chain changed"); end
    endtask

    task automatic test_random;
        int idx, nflip, sel;
        logic [143:0] img, e;
        for (int it = 0; it < 6; it++) begin
            idx = (it == 0) ? 96 : (it == 1) ? 1 : int'($urandom_range(1, 96));
            e = exp_img(idx);
            img = e;
            nflip = int'($urandom_range(0, 6));
            for (int f = 0; f < nflip; f++) img[$urandom_range(0, 143)] ^= 1'b1;
            load_chain(img);
            do_read(idx, 0);
            tests_run++;
            if (lat != 148 || mc_o !== 8'(ref_mismatch(img, e)) || m_o !== (ref_mismatch(img, e) == 0)) begin
                tests_failed++;
                $display("FAIL random idx=%0d: lat=%0d cnt=%0d match=%b want 148 %0d %b",
                         idx, lat, mc_o, m_o, ref_mismatch(img, e), ref_mismatch(img, e) == 0);
            end
            sel = int'($urandom_range(0, 8));
            rd_sel = 4'(sel); #1;
            tests_run++;
            if (rd_data !== img[16*sel +: 16]) begin
                tests_failed++; $display("FAIL random_rd idx=%0d sel=%0d: got %h want %h", idx, sel, rd_data, img[16*sel +: 16]);
            end
        end
    endtask

    task automatic test_back_to_back;
        load_chain(exp_img(10));
        do_read(10, 50);
        tests_run++;
        if (ena_cnt != 144 || done_cnt != 1 || busy_after != 0 || lat != 148 || m_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_back: ena=%0d dones=%0d busy_after=%0d lat=%0d match=%b want 144 1 0 148 1",
                     ena_cnt, done_cnt, busy_after, lat, m_o);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        load_chain(exp_img(10));
        @(negedge clk); start = 1'b1; freq_idx = 8'd10;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (scanclkena) n++;
            if (n == 70) break;
            @(negedge clk);
        end
        tests_run++;
        if (n != 70) begin tests_failed++; $display("FAIL reset_mid_reach: shift cycles %0d want 70", n); end
        #5 rst_n = 1'b0;
        #1;
        tests_run++;
        if (scanclkena !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 14'd0 || mismatch_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: ena=%b busy=%b done=%b addr=%0d cnt=%0d want 0", scanclkena, busy, done, rom_addr, mismatch_cnt);
        end
        @(negedge clk); rst_n = 1'b1;
        load_chain(exp_img(10));
        do_read(10, 0);
        tests_run++;
        if (lat != 148 || ena_cnt != 144 || m_o !== 1'b1 || mc_o !== 8'd0) begin
            tests_failed++; $display("FAIL reset_mid_recover: lat=%0d ena=%0d match=%b cnt=%0d want 148 144 1 0", lat, ena_cnt, m_o, mc_o);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom_mem[i] = 1'($urandom);
        chain_init = '0; chain2_init = '0; chain = '0; chain2 = '0;
        test_reset;
        test_match;
        test_flip;
        test_invalid;
        test_inverted;
        test_saturate;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
